// File: rtl/branch_target_buffer.sv
// Fetch-stage branch target buffer: 2-way set-associative, LRU replacement.
// Combinational lookup of if_pc; resolved taken branches from WB allocate
// or refresh entries. Saturating hit and allocation counters.
module branch_target_buffer #(
  parameter int SETS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] if_pc,
  input  logic        stall,
  input  logic        lc_pred_taken,
  input  logic        wbisbranch,
  input  logic        actual_taken,
  input  logic [15:0] wb_pcplus2,
  input  logic [15:0] wb_target,
  output logic        btb_hit,
  output logic [15:0] btb_target,
  output logic        pred_redirect,
  output logic [15:0] next_pc_pred,
  output logic [15:0] hit_count,
  output logic [15:0] alloc_count
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 15 - IDX;

  // Per-way storage; only valid and LRU are control state and get reset.
  logic [SETS-1:0]  valid_q [2];
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [15:0]      target_q[2][SETS];
  logic [SETS-1:0]  lru_q;

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit0;
  logic             rd_hit1;

  logic [15:0]      wb_pc;
  logic [IDX-1:0]   wb_idx;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_hit0;
  logic             wb_hit1;
  logic             wb_way;
  logic             wb_we;
  logic             wb_alloc;

  logic             unused_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign unused_bits = ^{if_pc[0], wb_pc[0]};

  // Lookup: compare both ways of the fetch set; way 0 wins a double hit.
  always_comb begin
    rd_idx        = if_pc[IDX:1];
    rd_tag        = if_pc[15:IDX+1];
    rd_hit0       = valid_q[0][rd_idx] && (tag_q[0][rd_idx] == rd_tag);
    rd_hit1       = valid_q[1][rd_idx] && (tag_q[1][rd_idx] == rd_tag);
    btb_hit       = rd_hit0 | rd_hit1;
    btb_target    = 16'h0000;
    if (rd_hit0)
      btb_target  = target_q[0][rd_idx];
    else if (rd_hit1)
      btb_target  = target_q[1][rd_idx];
    pred_redirect = btb_hit & lc_pred_taken;
    next_pc_pred  = pred_redirect ? btb_target : if_pc + 16'd2;
  end

  // WB side: locate the branch, pick the way to write (hit way, else first
  // invalid way, else the LRU way).
  always_comb begin
    wb_pc    = wb_pcplus2 - 16'd2;
    wb_idx   = wb_pc[IDX:1];
    wb_tag   = wb_pc[15:IDX+1];
    wb_hit0  = valid_q[0][wb_idx] && (tag_q[0][wb_idx] == wb_tag);
    wb_hit1  = valid_q[1][wb_idx] && (tag_q[1][wb_idx] == wb_tag);
    wb_we    = wbisbranch & actual_taken;
    wb_alloc = wb_we & ~(wb_hit0 | wb_hit1);
    if (wb_hit0)
      wb_way = 1'b0;
    else if (wb_hit1)
      wb_way = 1'b1;
    else if (!valid_q[0][wb_idx])
      wb_way = 1'b0;
    else if (!valid_q[1][wb_idx])
      wb_way = 1'b1;
    else
      wb_way = lru_q[wb_idx];
  end

  // Control state: valid bits, LRU and counters. The WB LRU write comes
  // last so it overrides a same-set lookup LRU write on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q[0]  <= '0;
      valid_q[1]  <= '0;
      lru_q       <= '0;
      hit_count   <= '0;
      alloc_count <= '0;
    end else begin
      if (!stall && btb_hit) begin
        lru_q[rd_idx] <= rd_hit0;
        hit_count     <= sat_inc(hit_count);
      end
      if (wb_we) begin
        valid_q[wb_way][wb_idx] <= 1'b1;
        lru_q[wb_idx]           <= ~wb_way;
        if (wb_alloc)
          alloc_count <= sat_inc(alloc_count);
      end
    end
  end

  // Tag/target storage; stale contents are masked by the cleared valid bits.
  always_ff @(posedge clk) begin
    if (wb_we) begin
      tag_q[wb_way][wb_idx]    <= wb_tag;
      target_q[wb_way][wb_idx] <= wb_target;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (SETS = 8).
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_pc;
  logic        stall;
  logic        lc_pred_taken;
  logic        wbisbranch;
  logic        actual_taken;
  logic [15:0] wb_pcplus2;
  logic [15:0] wb_target;
  logic        btb_hit;
  logic [15:0] btb_target;
  logic        pred_redirect;
  logic [15:0] next_pc_pred;
  logic [15:0] hit_count;
  logic [15:0] alloc_count;

  int total = 0;
  int bad   = 0;

  branch_target_buffer #(.SETS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_pc        (if_pc),
    .stall        (stall),
    .lc_pred_taken(lc_pred_taken),
    .wbisbranch   (wbisbranch),
    .actual_taken (actual_taken),
    .wb_pcplus2   (wb_pcplus2),
    .wb_target    (wb_target),
    .btb_hit      (btb_hit),
    .btb_target   (btb_target),
    .pred_redirect(pred_redirect),
    .next_pc_pred (next_pc_pred),
    .hit_count    (hit_count),
    .alloc_count  (alloc_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle taken-branch writeback with the fetch PC parked on a miss.
  task automatic wb_taken(input logic [15:0] pcplus2, input logic [15:0] tgt);
    if_pc        = 16'h4000;
    wbisbranch   = 1'b1;
    actual_taken = 1'b1;
    wb_pcplus2   = pcplus2;
    wb_target    = tgt;
    step();
    wbisbranch   = 1'b0;
    actual_taken = 1'b0;
  endtask

  // Combinational probe of one fetch PC.
  task automatic probe(input string tag, input logic [15:0] pc,
                       input logic hit, input logic [15:0] tgt);
    if_pc = pc;
    #1;
    check_eq({tag, "_hit"}, btb_hit, hit);
    check_eq({tag, "_tgt"}, btb_target, tgt);
  endtask

  initial begin
    reset         = 1'b1;
    if_pc         = 16'h3000;
    stall         = 1'b0;
    lc_pred_taken = 1'b1;
    wbisbranch    = 1'b0;
    actual_taken  = 1'b0;
    wb_pcplus2    = 16'h0000;
    wb_target     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hit", btb_hit, 1'b0);
    check_eq("rst_tgt", btb_target, 16'h0000);
    check_eq("rst_redir", pred_redirect, 1'b0);
    check_eq("rst_npc", next_pc_pred, 16'h3002);
    check_eq("rst_hcnt", hit_count, 16'h0000);
    check_eq("rst_acnt", alloc_count, 16'h0000);
    reset = 1'b0;
    #1;
    check_eq("post_rst_npc", next_pc_pred, 16'h3002);

    // Allocate 0x3010 -> 0x3040 (set 0, way 0).
    wb_taken(16'h3012, 16'h3040);
    if_pc = 16'h3010;
    lc_pred_taken = 1'b1;
    #1;
    check_eq("alloc_hit", btb_hit, 1'b1);
    check_eq("alloc_npc", next_pc_pred, 16'h3040);
    check_eq("alloc_redir", pred_redirect, 1'b1);
    check_eq("alloc_acnt", alloc_count, 16'd1);
    lc_pred_taken = 1'b0;
    #1;
    check_eq("nt_pred_npc", next_pc_pred, 16'h3012);
    check_eq("nt_pred_redir", pred_redirect, 1'b0);
    lc_pred_taken = 1'b1;

    // Fill set 0 way 1, touch 0x3010, then evict the LRU way (0x3110).
    wb_taken(16'h3112, 16'h3150);
    probe("ev_3110a", 16'h3110, 1'b1, 16'h3150);
    probe("ev_3010a", 16'h3010, 1'b1, 16'h3040);
    step();
    check_eq("lookup_hcnt", hit_count, 16'd1);
    wb_taken(16'h3212, 16'h3250);
    probe("ev_3110b", 16'h3110, 1'b0, 16'h0000);
    probe("ev_3010b", 16'h3010, 1'b1, 16'h3040);
    probe("ev_3210b", 16'h3210, 1'b1, 16'h3250);
    check_eq("ev_acnt", alloc_count, 16'd3);

    // Target refresh on hit, then not-taken leaves the entry alone.
    wb_taken(16'h3012, 16'h3080);
    probe("refresh", 16'h3010, 1'b1, 16'h3080);
    check_eq("refresh_acnt", alloc_count, 16'd3);
    if_pc        = 16'h4000;
    wbisbranch   = 1'b1;
    actual_taken = 1'b0;
    wb_pcplus2   = 16'h3012;
    wb_target    = 16'h3999;
    step();
    wbisbranch   = 1'b0;
    probe("not_taken", 16'h3010, 1'b1, 16'h3080);
    check_eq("not_taken_acnt", alloc_count, 16'd3);

    // Same-cycle collision in set 1: lookup hits way 0 while WB fills way 1.
    wb_taken(16'h3014, 16'h3060);
    wbisbranch   = 1'b1;
    actual_taken = 1'b1;
    wb_pcplus2   = 16'h3114;
    wb_target    = 16'h3070;
    probe("coll_nofwd", 16'h3112, 1'b0, 16'h0000);
    probe("coll_look", 16'h3012, 1'b1, 16'h3060);
    step();
    wbisbranch   = 1'b0;
    actual_taken = 1'b0;
    check_eq("coll_hcnt", hit_count, 16'd2);
    check_eq("coll_acnt", alloc_count, 16'd5);
    probe("coll_new", 16'h3112, 1'b1, 16'h3070);
    // LRU must point at way 0, so the next allocation evicts 0x3012.
    wb_taken(16'h3214, 16'h3090);
    probe("coll_evict0", 16'h3012, 1'b0, 16'h0000);
    probe("coll_keep1", 16'h3112, 1'b1, 16'h3070);
    probe("coll_third", 16'h3212, 1'b1, 16'h3090);
    check_eq("coll_acnt2", alloc_count, 16'd6);

    // Fall-through wraps mod 2^16.
    if_pc = 16'hFFFE;
    lc_pred_taken = 1'b0;
    #1;
    check_eq("wrap_npc", next_pc_pred, 16'h0000);
    lc_pred_taken = 1'b1;

    // Stalled hits are not counted.
    if_pc = 16'h3010;
    stall = 1'b1;
    repeat (5) step();
    check_eq("stall_hcnt", hit_count, 16'd2);
    stall = 1'b0;

    // Drive hit_count to saturation.
    repeat (65532) @(posedge clk);
    #1;
    check_eq("sat_fffe", hit_count, 16'hFFFE);
    step();
    check_eq("sat_ffff", hit_count, 16'hFFFF);
    repeat (3) step();
    check_eq("sat_hold", hit_count, 16'hFFFF);

    // Async reset mid-cycle, held across an edge with a pending allocation.
    wbisbranch   = 1'b1;
    actual_taken = 1'b1;
    wb_pcplus2   = 16'h3412;
    wb_target    = 16'h3500;
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_hcnt", hit_count, 16'h0000);
    check_eq("arst_acnt", alloc_count, 16'h0000);
    check_eq("arst_hit", btb_hit, 1'b0);
    check_eq("arst_npc", next_pc_pred, 16'h3012);
    step();
    reset        = 1'b0;
    wbisbranch   = 1'b0;
    actual_taken = 1'b0;
    probe("arst_discard", 16'h3410, 1'b0, 16'h0000);
    probe("arst_empty", 16'h3010, 1'b0, 16'h0000);
    check_eq("arst_acnt2", alloc_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-stage branch target buffer for the LC-3b pipeline. It sits beside the local branch predictor in IF. Each cycle it looks up `if_pc`; on a hit, it combines the predictor's `lc_pred_taken` to produce the predicted next fetch PC. At writeback, resolved taken branches allocate or refresh entries, so that later fetches of the same branch redirect without waiting for decode.

## Interface
- `SETS`, default 8, number of sets. Must be a power of 2, 2..128. `IDX = log2(SETS)`. Associativity is fixed at 2 ways.
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_pc` in 16: fetch PC (`lc3b_word`), word-aligned.
- `stall` in 1: IF stalled. While high, lookup-side LRU and counter updates are suppressed.
- `lc_pred_taken` in 1: direction prediction for `if_pc` from the local predictor, same cycle.
- `wbisbranch` in 1: WB stage holds a resolved conditional branch.
- `actual_taken` in 1: resolved direction of the WB branch.
- `wb_pcplus2` in 16: PC+2 of the WB branch.
- `wb_target` in 16: resolved target of the WB branch.
- `btb_hit` out 1: `if_pc` tag matches a valid entry.
- `btb_target` out 16: stored target of the hitting way. 0 when there is no hit.
- `pred_redirect` out 1: `btb_hit & lc_pred_taken`.
- `next_pc_pred` out 16: `pred_redirect ? btb_target : if_pc + 2`, with mod-2^16 wrap.
- `hit_count` out 16: saturating count of non-stalled lookup hits.
- `alloc_count` out 16: saturating count of new-entry allocations.

## Operation
- Address split:
  - index = `pc[IDX:1]`
  - tag = `pc[15:IDX+1]`
  - `wb_pc = wb_pcplus2 - 2`, mod 2^16
- State per set:
  - two ways, each holding {valid, tag, target}
  - one LRU bit, naming the least-recently-used way
- Lookup is combinational over both ways of set `if_pc[IDX:1]`.
  - If both ways hit (illegal state, never produced by update), way 0 wins.
- Lookup LRU update: on a clock edge with `!stall & btb_hit`, set that set's LRU to the way that did not hit.
- Update, on a clock edge with `wbisbranch & actual_taken`:
  - **WB tag hits way w:** write `target = wb_target`; set LRU to the other way. Not an allocation.
  - **Miss:** choose the victim in this order: first invalid way, with way 0 preferred; if both are valid, the LRU way. Write {1, tag, `wb_target`} to the victim; set LRU to the other way. `alloc_count` += 1.
- `wbisbranch & !actual_taken`: no state change. Existing entries are kept, since direction is owned by the predictor.
- Same-cycle lookup LRU update and WB update to the same set: the WB update's LRU value wins.
- No write-to-read forwarding: a lookup in the same cycle as an update sees the pre-edge contents.
- Counters saturate at 0xFFFF and never wrap.
  - `hit_count` increments on edges with `!stall & btb_hit`.

## Timing
- Lookup outputs (`btb_hit`, `btb_target`, `pred_redirect`, `next_pc_pred`) are combinational from `if_pc`, `lc_pred_taken` and the current state. Lookup has zero-cycle latency.
- An update is visible to lookups on the cycle after the clock edge that performs it.
- Reset is asserted asynchronously; its effect is immediate and independent of `clk`. It clears:
  - all valid bits, to 0
  - all LRU bits, to way 0
  - both counters, to 0
- Tag and target storage need not be reset.
- Output values while or after reset:
  - `btb_hit` = 0
  - `btb_target` = 0
  - `pred_redirect` = 0
  - `next_pc_pred` = `if_pc + 2`
  - counters = 0
- Reset mid-update: the update is discarded. The first post-reset edge behaves as from an empty table.
- `stall` does not block WB updates.

## Test plan
- **Reset state:** after reset, `if_pc` = 0x3000, `lc_pred_taken` = 1 -> `btb_hit` = 0, `next_pc_pred` = 0x3002, counters 0.
- **Allocate then hit:** WB branch with `wb_pcplus2` = 0x3012, taken, target 0x3040. Next cycle, `if_pc` = 0x3010, `lc_pred_taken` = 1 -> `btb_hit` = 1, `next_pc_pred` = 0x3040, `alloc_count` = 1. With `lc_pred_taken` = 0 -> `next_pc_pred` = 0x3012.
- **Eviction (SETS = 8):**
  - allocate PCs 0x3010 and 0x3110 (same set) -> both hit
  - look up 0x3010 with `stall` = 0
  - allocate 0x3210 -> 0x3110 is evicted; 0x3010 and 0x3210 hit; `alloc_count` = 3
- **Target refresh and not-taken:**
  - existing entry 0x3010; WB taken with new target 0x3080 -> hit returns 0x3080, `alloc_count` unchanged
  - WB not-taken for 0x3010 -> entry still hits
- **Same-cycle collision:** lookup hits way 0 of a set while WB allocates into way 1 of that set -> LRU ends at way 0; the lookup in that cycle still misses the new entry.
- **Counter saturation and stall:**
  - force 0xFFFF hits -> `hit_count` holds at 0xFFFF
  - hits with `stall` = 1 do not count
  - async reset pulse mid-cycle clears the counters immediately
